// File: rtl/prog_wave_gen.sv
// prog_wave_gen: multi-channel programmable PWM/clock generator with shadowed period/high registers.
// Optional phase-align input sync_start is built only when WAVE_GEN_SYNC_EN is defined.
module prog_wave_gen #(
  parameter int CHANNELS   = 2,
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 4,
  parameter int DEF_HIGH   = 2
) (
  input  logic                clk,
  input  logic                reset,
`ifdef WAVE_GEN_SYNC_EN
  input  logic                sync_start,
`endif
  input  logic [CHANNELS-1:0] en,
  input  logic                load,
  input  logic [2:0]          ch_sel,
  input  logic [CNT_W-1:0]    period_in,
  input  logic [CNT_W-1:0]    high_in,
  output logic [CHANNELS-1:0] wave,
  output logic [CHANNELS-1:0] tick
);
  typedef logic [CNT_W-1:0] cnt_t;
  cnt_t shd_p_q [CHANNELS];
  cnt_t shd_p_d [CHANNELS];
  cnt_t shd_h_q [CHANNELS];
  cnt_t shd_h_d [CHANNELS];
  cnt_t act_p_q [CHANNELS];
  cnt_t act_p_d [CHANNELS];
  cnt_t act_h_q [CHANNELS];
  cnt_t act_h_d [CHANNELS];
  cnt_t cnt_q   [CHANNELS];
  cnt_t cnt_d   [CHANNELS];
  logic [CHANNELS-1:0] run_q, wave_q, wave_d, tick_q, tick_d;
  logic [CHANNELS-1:0] ld, start, wrap;
  logic sync;
`ifdef WAVE_GEN_SYNC_EN
  assign sync = sync_start;
`else
  assign sync = 1'b0;
`endif
  // start: first enabled cycle (or sync) opens a period at cnt=0 taking the shadow pair
  always_comb begin
    wave_d = '0;
    tick_d = '0;
    ld     = '0;
    start  = '0;
    wrap   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ld[i]      = load && (ch_sel == 3'(i));
      start[i]   = en[i] && (!run_q[i] || sync);
      wrap[i]    = en[i] && run_q[i] && (act_p_q[i] != '0) && (cnt_q[i] == act_p_q[i] - cnt_t'(1));
      shd_p_d[i] = ld[i] ? period_in : shd_p_q[i];
      shd_h_d[i] = ld[i] ? high_in : shd_h_q[i];
      act_p_d[i] = (start[i] || wrap[i]) ? shd_p_q[i] : (ld[i] && !en[i]) ? period_in : act_p_q[i];
      act_h_d[i] = (start[i] || wrap[i]) ? shd_h_q[i] : (ld[i] && !en[i]) ? high_in : act_h_q[i];
      cnt_d[i]   = (!en[i] || start[i] || wrap[i] || act_p_q[i] == '0) ? '0 : cnt_q[i] + cnt_t'(1);
      wave_d[i]  = en[i] && (act_p_d[i] != '0) && (cnt_d[i] < act_h_d[i]);
      tick_d[i]  = en[i] && (act_p_d[i] != '0) && (cnt_d[i] == act_p_d[i] - cnt_t'(1));
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shd_p_q[i] <= cnt_t'(DEF_PERIOD);
        shd_h_q[i] <= cnt_t'(DEF_HIGH);
        act_p_q[i] <= cnt_t'(DEF_PERIOD);
        act_h_q[i] <= cnt_t'(DEF_HIGH);
        cnt_q[i]   <= '0;
      end
      run_q  <= '0;
      wave_q <= '0;
      tick_q <= '0;
    end else begin
      shd_p_q <= shd_p_d;
      shd_h_q <= shd_h_d;
      act_p_q <= act_p_d;
      act_h_q <= act_h_d;
      cnt_q   <= cnt_d;
      run_q   <= en;
      wave_q  <= wave_d;
      tick_q  <= tick_d;
    end
  end
  assign wave = wave_q;
  assign tick = tick_q;
endmodule
